// File: rtl/dift_tag_override_unit.sv
// dift_tag_override_unit
//
// In-line DIFT tag override stage for one TCDM-style bus port. Every granted
// request is matched against NR_REGIONS programmable address windows; the
// override mode of the winning window (lowest index) is captured into a
// per-transaction FIFO. When the matching response returns, the queued mode
// is applied to its tag bits [32+TAG_W-1:32], so the override always follows
// the address of the original request.
//
// Optional feature: define DIFT_TAG_OVR_STATS_EN to add a saturating 32-bit
// counter of read responses whose tag was overridden (MODE 1..3), readable
// at config word 3*NR_REGIONS+1 and cleared by any write to that word.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   s_*                      upstream request / response (wen=1 means read)
//   m_*                      downstream request / response
//   cfg_req_i/we/addr/wdata  single-cycle config access, always accepted
//   cfg_rdata_o              registered read data, valid the cycle after a read
//   err_o                    sticky: a response arrived with an empty FIFO
//
// Config map (word index): region r -> 3r START, 3r+1 END (exclusive),
// 3r+2 CTRL {VALUE[4+TAG_W-1:4], MODE[2:1], EN[0]}; 3*NR_REGIONS STATUS
// {fifo_empty, fifo_full, err}, write 1 to bit 0 clears err.

module dift_tag_override_unit #(
  parameter int TAG_W           = 4,
  parameter int NR_REGIONS      = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // upstream request
  input  logic                  s_req_i,
  input  logic [31:0]           s_add_i,
  input  logic                  s_wen_i,
  input  logic [3:0]            s_be_i,
  input  logic [32+TAG_W-1:0]   s_wdata_i,
  output logic                  s_gnt_o,
  // upstream response
  output logic                  s_r_valid_o,
  output logic                  s_r_opc_o,
  output logic [32+TAG_W-1:0]   s_r_rdata_o,
  // downstream request
  output logic                  m_req_o,
  output logic [31:0]           m_add_o,
  output logic                  m_wen_o,
  output logic [3:0]            m_be_o,
  output logic [32+TAG_W-1:0]   m_wdata_o,
  input  logic                  m_gnt_i,
  // downstream response
  input  logic                  m_r_valid_i,
  input  logic                  m_r_opc_i,
  input  logic [32+TAG_W-1:0]   m_r_rdata_i,
  // configuration
  input  logic                  cfg_req_i,
  input  logic                  cfg_we_i,
  input  logic [5:0]            cfg_addr_i,
  input  logic [31:0]           cfg_wdata_i,
  output logic [31:0]           cfg_rdata_o,
  output logic                  err_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [5:0] STATUS_IDX = 6'(3 * NR_REGIONS);
  localparam logic [5:0] STATS_IDX  = 6'(3 * NR_REGIONS + 1);

  // Apply an override mode to a tag.
  function automatic logic [TAG_W-1:0] apply_mode(input logic [1:0]       mode,
                                                  input logic [TAG_W-1:0] tag,
                                                  input logic [TAG_W-1:0] value);
    logic [TAG_W-1:0] res;
    case (mode)
      2'd1:    res = '1;
      2'd2:    res = '0;
      2'd3:    res = value;
      default: res = tag;
    endcase
    return res;
  endfunction

  // Assemble the CTRL register image for read-back.
  function automatic logic [31:0] pack_ctrl(input logic             en,
                                            input logic [1:0]       mode,
                                            input logic [TAG_W-1:0] value);
    logic [31:0] w;
    w            = '0;
    w[0]         = en;
    w[2:1]       = mode;
    w[4 +: TAG_W] = value;
    return w;
  endfunction

  // Region registers
  logic [31:0]      reg_start [NR_REGIONS];
  logic [31:0]      reg_end   [NR_REGIONS];
  logic             reg_en    [NR_REGIONS];
  logic [1:0]       reg_mode  [NR_REGIONS];
  logic [TAG_W-1:0] reg_value [NR_REGIONS];

  // Decision FIFO
  logic [1:0]       fifo_mode  [MAX_OUTSTANDING];
  logic [TAG_W-1:0] fifo_value [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  logic             hit;
  logic [1:0]       req_mode;
  logic [TAG_W-1:0] req_value;
  logic [1:0]       resp_mode;
  logic [TAG_W-1:0] resp_value;
  logic             err_flag;
  logic             status_wr;
  logic [31:0]      rd_word;

  assign full  = (count == CNT_W'(MAX_OUTSTANDING));
  assign empty = (count == '0);

  // Request path: pass-through, throttled only when the FIFO is full
  assign m_req_o   = s_req_i && !full;
  assign s_gnt_o   = m_gnt_i && !full;
  assign m_add_o   = s_add_i;
  assign m_wen_o   = s_wen_i;
  assign m_be_o    = s_be_i;
  assign m_wdata_o = s_wdata_i;

  assign push = s_req_i && s_gnt_o;
  // A response with an empty FIFO is forwarded without popping.
  assign pop  = m_r_valid_i && !empty;

  // Region match: scan upward and stop at the first hit, so the lowest
  // index wins on overlap.
  always_comb begin
    hit       = 1'b0;
    req_mode  = 2'd0;
    req_value = '0;
    for (int r = 0; r < NR_REGIONS; r++) begin
      if (!hit && reg_en[r] && (s_add_i >= reg_start[r]) && (s_add_i < reg_end[r])) begin
        hit       = 1'b1;
        req_mode  = reg_mode[r];
        req_value = reg_value[r];
      end
    end
  end

  // Grant cycle -> FIFO: capture the decision for this transaction
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mode[wr_ptr]  <= req_mode;
      fifo_value[wr_ptr] <= req_value;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO head -> response: apply the queued mode to the returning tag
  always_comb begin
    resp_mode  = 2'd0;
    resp_value = '0;
    if (!empty) begin
      resp_mode  = fifo_mode[rd_ptr];
      resp_value = fifo_value[rd_ptr];
    end
  end

  assign s_r_valid_o = m_r_valid_i;
  assign s_r_opc_o   = m_r_opc_i;
  assign s_r_rdata_o = {apply_mode(resp_mode, m_r_rdata_i[32+TAG_W-1:32], resp_value),
                        m_r_rdata_i[31:0]};

  // Configuration writes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NR_REGIONS; r++) begin
        reg_start[r] <= '0;
        reg_end[r]   <= '0;
        reg_en[r]    <= 1'b0;
        reg_mode[r]  <= 2'd0;
        reg_value[r] <= '0;
      end
    end else if (cfg_req_i && cfg_we_i) begin
      for (int r = 0; r < NR_REGIONS; r++) begin
        if (cfg_addr_i == 6'(3 * r))     reg_start[r] <= cfg_wdata_i;
        if (cfg_addr_i == 6'(3 * r + 1)) reg_end[r]   <= cfg_wdata_i;
        if (cfg_addr_i == 6'(3 * r + 2)) begin
          reg_en[r]    <= cfg_wdata_i[0];
          reg_mode[r]  <= cfg_wdata_i[2:1];
          reg_value[r] <= cfg_wdata_i[4 +: TAG_W];
        end
      end
    end
  end

  assign status_wr = cfg_req_i && cfg_we_i && (cfg_addr_i == STATUS_IDX);

  // A new error in the same cycle as a clear wins, so no event is lost.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_flag <= 1'b0;
    end else if (m_r_valid_i && empty) begin
      err_flag <= 1'b1;
    end else if (status_wr && cfg_wdata_i[0]) begin
      err_flag <= 1'b0;
    end
  end

  assign err_o = err_flag;

`ifdef DIFT_TAG_OVR_STATS_EN
  logic             fifo_rd [MAX_OUTSTANDING];
  logic [31:0]      stats_cnt;
  logic             stats_inc;
  logic             stats_clr;

  always_ff @(posedge clk_i) begin
    if (push) fifo_rd[wr_ptr] <= s_wen_i;
  end

  assign stats_inc = pop && fifo_rd[rd_ptr] && (fifo_mode[rd_ptr] != 2'd0);
  assign stats_clr = cfg_req_i && cfg_we_i && (cfg_addr_i == STATS_IDX);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stats_cnt <= '0;
    end else if (stats_clr) begin
      stats_cnt <= '0;
    end else if (stats_inc && (stats_cnt != 32'hFFFF_FFFF)) begin
      stats_cnt <= stats_cnt + 32'd1;
    end
  end
`endif

  // Configuration read mux; unmapped words read as zero
  always_comb begin
    rd_word = '0;
    for (int r = 0; r < NR_REGIONS; r++) begin
      if (cfg_addr_i == 6'(3 * r))     rd_word = reg_start[r];
      if (cfg_addr_i == 6'(3 * r + 1)) rd_word = reg_end[r];
      if (cfg_addr_i == 6'(3 * r + 2)) rd_word = pack_ctrl(reg_en[r], reg_mode[r], reg_value[r]);
    end
    if (cfg_addr_i == STATUS_IDX) rd_word = {29'd0, empty, full, err_flag};
`ifdef DIFT_TAG_OVR_STATS_EN
    if (cfg_addr_i == STATS_IDX)  rd_word = stats_cnt;
`endif
  end

  // Read data register: holds its value until the next read
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_rdata_o <= '0;
    end else if (cfg_req_i && !cfg_we_i) begin
      cfg_rdata_o <= rd_word;
    end
  end

endmodule

// File: tb/tb_dift_tag_override_unit.sv
module tb_dift_tag_override_unit;

  localparam int TAG_W = 4;
  localparam int NR    = 4;
  localparam int MAXO  = 4;
  localparam int DW    = 32 + TAG_W;
  localparam int STATUS_W = 3 * NR;
  localparam int STATS_W  = 3 * NR + 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          s_req_i;
  logic [31:0]   s_add_i;
  logic          s_wen_i;
  logic [3:0]    s_be_i;
  logic [DW-1:0] s_wdata_i;
  logic          s_gnt_o;
  logic          s_r_valid_o;
  logic          s_r_opc_o;
  logic [DW-1:0] s_r_rdata_o;
  logic          m_req_o;
  logic [31:0]   m_add_o;
  logic          m_wen_o;
  logic [3:0]    m_be_o;
  logic [DW-1:0] m_wdata_o;
  logic          m_gnt_i;
  logic          m_r_valid_i;
  logic          m_r_opc_i;
  logic [DW-1:0] m_r_rdata_i;
  logic          cfg_req_i;
  logic          cfg_we_i;
  logic [5:0]    cfg_addr_i;
  logic [31:0]   cfg_wdata_i;
  logic [31:0]   cfg_rdata_o;
  logic          err_o;

  dift_tag_override_unit #(.TAG_W(TAG_W), .NR_REGIONS(NR), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_req_i(s_req_i), .s_add_i(s_add_i), .s_wen_i(s_wen_i), .s_be_i(s_be_i),
    .s_wdata_i(s_wdata_i), .s_gnt_o(s_gnt_o),
    .s_r_valid_o(s_r_valid_o), .s_r_opc_o(s_r_opc_o), .s_r_rdata_o(s_r_rdata_o),
    .m_req_o(m_req_o), .m_add_o(m_add_o), .m_wen_o(m_wen_o), .m_be_o(m_be_o),
    .m_wdata_o(m_wdata_o), .m_gnt_i(m_gnt_i),
    .m_r_valid_i(m_r_valid_i), .m_r_opc_i(m_r_opc_i), .m_r_rdata_i(m_r_rdata_i),
    .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
    .cfg_wdata_i(cfg_wdata_i), .cfg_rdata_o(cfg_rdata_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model state
  typedef struct packed {
    logic [1:0]       mode;
    logic [TAG_W-1:0] value;
    logic             rd;
  } ent_t;

  logic [31:0] md_start [NR];
  logic [31:0] md_end   [NR];
  logic [31:0] md_ctrl  [NR];
  ent_t        md_q[$];
  bit          md_err;
  int unsigned md_stats;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] ctrl_mask;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t lookup(input logic [31:0] addr, input logic rd);
    ent_t e;
    e = '0;
    e.rd = rd;
    for (int r = 0; r < NR; r++) begin
      if (md_ctrl[r][0] && md_start[r] <= addr && addr < md_end[r]) begin
        e.mode  = md_ctrl[r][2:1];
        e.value = md_ctrl[r][4 +: TAG_W];
        return e;
      end
    end
    return e;
  endfunction

  function automatic logic [TAG_W-1:0] apply(input ent_t e, input logic [TAG_W-1:0] tag);
    if (e.mode == 2'd1) return {TAG_W{1'b1}};
    if (e.mode == 2'd2) return '0;
    if (e.mode == 2'd3) return e.value;
    return tag;
  endfunction

  function automatic logic [31:0] model_word(input int a);
    if (a < 3 * NR) begin
      if (a % 3 == 0) return md_start[a / 3];
      if (a % 3 == 1) return md_end[a / 3];
      return md_ctrl[a / 3];
    end
    if (a == STATUS_W)
      return {29'd0, md_q.size() == 0, md_q.size() == MAXO, md_err};
`ifdef DIFT_TAG_OVR_STATS_EN
    if (a == STATS_W) return md_stats;
`endif
    return 32'd0;
  endfunction

  task automatic model_clear();
    md_q.delete();
    md_err   = 1'b0;
    md_stats = 0;
    for (int r = 0; r < NR; r++) begin
      md_start[r] = '0;
      md_end[r]   = '0;
      md_ctrl[r]  = '0;
    end
  endtask

  task automatic idle_inputs();
    s_req_i = 0; s_add_i = '0; s_wen_i = 0; s_be_i = '0; s_wdata_i = '0;
    m_gnt_i = 0; m_r_valid_i = 0; m_r_opc_i = 0; m_r_rdata_i = '0;
    cfg_req_i = 0; cfg_we_i = 0; cfg_addr_i = '0; cfg_wdata_i = '0;
  endtask

  // One bus cycle: drive, check combinational outputs, update model, clock.
  task automatic bus(input bit req, input logic [31:0] add, input bit wen,
                     input bit gnt, input bit rv, input logic [DW-1:0] rdata);
    bit               full;
    ent_t             e;
    logic [DW-1:0]    wd;
    logic             opc;
    wd  = {4'($urandom), 32'($urandom)};
    opc = 1'($urandom);
    idle_inputs();
    s_req_i = req; s_add_i = add; s_wen_i = wen; s_be_i = 4'($urandom); s_wdata_i = wd;
    m_gnt_i = gnt; m_r_valid_i = rv; m_r_rdata_i = rdata; m_r_opc_i = opc;
    #2;
    full = (md_q.size() == MAXO);
    chk("gnt", 64'(s_gnt_o), 64'(gnt && !full));
    chk("m_req", 64'(m_req_o), 64'(req && !full));
    if (req) begin
      chk("m_add", 64'(m_add_o), 64'(add));
      chk("m_wdata", 64'(m_wdata_o), 64'(wd));
      chk("m_wen", 64'(m_wen_o), 64'(wen));
    end
    if (rv) begin
      e = (md_q.size() > 0) ? md_q[0] : '0;
      chk("r_valid", 64'(s_r_valid_o), 64'(1));
      chk("r_opc", 64'(s_r_opc_o), 64'(opc));
      chk("r_rdata", 64'(s_r_rdata_o), 64'({apply(e, rdata[DW-1:32]), rdata[31:0]}));
      if (md_q.size() > 0) begin
        if (e.rd && e.mode != 2'd0 && md_stats != 32'hFFFF_FFFF) md_stats++;
        void'(md_q.pop_front());
      end else begin
        md_err = 1'b1;
      end
    end
    if (req && gnt && !full) md_q.push_back(lookup(add, wen));
    @(posedge clk_i); #1;
    chk("err", 64'(err_o), 64'(md_err));
  endtask

  task automatic cfg_wr(input int a, input logic [31:0] d);
    idle_inputs();
    cfg_req_i = 1; cfg_we_i = 1; cfg_addr_i = 6'(a); cfg_wdata_i = d;
    @(posedge clk_i); #1;
    cfg_req_i = 0; cfg_we_i = 0;
    if (a < 3 * NR) begin
      if (a % 3 == 0)      md_start[a / 3] = d;
      else if (a % 3 == 1) md_end[a / 3]   = d;
      else                 md_ctrl[a / 3]  = d & ctrl_mask;
    end else if (a == STATUS_W) begin
      if (d[0]) md_err = 1'b0;
    end else if (a == STATS_W) begin
      md_stats = 0;
    end
    chk("err_after_cfg", 64'(err_o), 64'(md_err));
  endtask

  task automatic cfg_rd(input string tag, input int a);
    logic [31:0] exp;
    idle_inputs();
    exp = model_word(a);
    cfg_req_i = 1; cfg_we_i = 0; cfg_addr_i = 6'(a);
    @(posedge clk_i); #1;
    cfg_req_i = 0;
    chk(tag, 64'(cfg_rdata_o), 64'(exp));
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1;
    @(posedge clk_i); #1;
    rst_i = 0;
    model_clear();
    chk("rst_err", 64'(err_o), 64'(0));
    chk("rst_cfg_rdata", 64'(cfg_rdata_o), 64'(0));
  endtask

  function automatic logic [DW-1:0] rsp(input logic [TAG_W-1:0] tag);
    return {tag, 32'($urandom)};
  endfunction

  initial begin
    ctrl_mask = 32'h7 | (((32'd1 << TAG_W) - 32'd1) << 4);
    idle_inputs();
    rst_i = 1;
    model_clear();
    @(posedge clk_i); @(posedge clk_i); #1;
    do_reset();

    // Pass-through with no regions, then STATUS shows empty FIFO only
    bus(1, 32'h1C00_0000, 1, 1, 0, '0);
    bus(0, 32'h0, 0, 0, 1, rsp(4'hA));
    cfg_rd("status_idle", STATUS_W);
    chk("status_const", 64'(cfg_rdata_o), 64'h4);

    // Overlapping regions 0 (MODE 1) and 1 (MODE 2): region 0 wins
    cfg_wr(0, 32'h1C00_0000); cfg_wr(1, 32'h1C01_0000); cfg_wr(2, 32'h3);
    cfg_wr(3, 32'h1C00_0000); cfg_wr(4, 32'h1C01_0000); cfg_wr(5, 32'h5);
    cfg_rd("ctrl0_rb", 2);
    cfg_rd("end1_rb", 4);
    bus(1, 32'h1C00_0100, 1, 1, 0, '0);
    bus(0, 32'h0, 0, 0, 1, rsp(4'h3));
    bus(1, 32'h1C01_0000, 1, 1, 0, '0);
    bus(0, 32'h0, 0, 0, 1, rsp(4'h6));

    // Region 2 MODE 3 VALUE 5; fill the FIFO and hold off a 5th request
    cfg_wr(6, 32'h2000_0000); cfg_wr(7, 32'h2000_1000); cfg_wr(8, 32'h57);
    bus(1, 32'h2000_0010, 1, 1, 0, '0);
    bus(1, 32'h3000_0000, 1, 1, 0, '0);
    bus(1, 32'h2000_0020, 1, 1, 0, '0);
    bus(1, 32'h3000_0040, 1, 1, 0, '0);
    cfg_rd("status_full", STATUS_W);
    bus(1, 32'h2000_0030, 1, 1, 0, '0);
    bus(1, 32'h2000_0030, 1, 1, 1, rsp(4'h9));
    bus(1, 32'h2000_0030, 1, 1, 1, rsp(4'h9));
    bus(0, 32'h0, 0, 0, 1, rsp(4'h1));
    bus(0, 32'h0, 0, 0, 1, rsp(4'hC));
    bus(0, 32'h0, 0, 0, 1, rsp(4'h2));

    // Reprogram region 2 while two reads are in flight
    bus(1, 32'h2000_0100, 1, 1, 0, '0);
    bus(1, 32'h2000_0104, 1, 1, 0, '0);
    cfg_wr(8, 32'h5);
    bus(1, 32'h2000_0108, 1, 1, 1, rsp(4'h8));
    bus(0, 32'h0, 0, 0, 1, rsp(4'h8));
    bus(0, 32'h0, 0, 0, 1, rsp(4'h8));

    // Response with an empty FIFO, then clear err through STATUS
    bus(0, 32'h0, 0, 0, 1, rsp(4'hB));
    cfg_rd("status_err", STATUS_W);
    cfg_wr(STATUS_W, 32'h1);
    cfg_rd("unmapped", 40);

    // Statistics: 3 overridden reads, 2 pass reads, 1 overridden write
    cfg_wr(STATS_W, 32'h0);
    for (int i = 0; i < 6; i++) begin
      bus(1, (i < 3) ? 32'h1C00_0000 + 32'(i * 4) : 32'h4000_0000, (i != 5), 1, 0, '0);
      if (i == 5) bus(1, 32'h1C00_0000, 0, 1, 0, '0);
      bus(0, 32'h0, 0, 0, 1, rsp(4'(i)));
      if (i == 5) bus(0, 32'h0, 0, 0, 1, rsp(4'h0));
    end
    cfg_rd("stats", STATS_W);

    // Reset mid-burst
    bus(1, 32'h1C00_0000, 1, 1, 0, '0);
    bus(1, 32'h2000_0000, 1, 1, 0, '0);
    do_reset();
    cfg_rd("status_after_rst", STATUS_W);
    cfg_rd("ctrl0_after_rst", 2);
    cfg_rd("stats_after_rst", STATS_W);
    bus(0, 32'h0, 0, 0, 1, rsp(4'h7));
    cfg_wr(STATUS_W, 32'h1);
    bus(1, 32'h1C00_0000, 1, 1, 0, '0);
    bus(0, 32'h0, 0, 0, 1, rsp(4'h7));

    // Randomized traffic over randomly programmed, overlapping regions
    for (int r = 0; r < NR; r++) begin
      logic [31:0] st;
      st = 32'h5000_0000 + 32'($urandom_range(0, 3)) * 32'h80;
      cfg_wr(3 * r, st);
      cfg_wr(3 * r + 1, st + 32'($urandom_range(1, 3)) * 32'h80);
      cfg_wr(3 * r + 2, $urandom);
    end
    cfg_wr(STATS_W, 32'h0);
    for (int c = 0; c < 300; c++) begin
      if (c % 60 == 59) cfg_wr(3 * $urandom_range(0, NR - 1) + 2, $urandom);
      bus(1'($urandom), 32'h5000_0000 + 32'($urandom_range(0, 32'h27F)), 1'($urandom),
          1'($urandom), ($urandom_range(0, 2) != 0) && (md_q.size() > 0), rsp(4'($urandom)));
    end
    while (md_q.size() > 0) bus(0, 32'h0, 0, 0, 1, rsp(4'($urandom)));
    cfg_rd("stats_random", STATS_W);
    cfg_rd("status_end", STATUS_W);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dift_tag_override_unit.md
# dift_tag_override_unit

Programmable, in-line DIFT tag override stage for one TCDM-style bus port, placed between an interconnect master port and a memory slave.
- Each accepted request is matched against `NR_REGIONS` software-programmable address ranges.
- The override mode of the matching region is captured at grant and queued per outstanding transaction.
- When the read response returns, the queued mode is applied to its tag bits, so the override always belongs to the request's address, not the address on the bus at response time.
- Enables hardware tag initialisation and runtime re-tagging of memory windows without rebuilding the address map.

## Interface
Parameters:
- `TAG_W`, 4, tag bits per data word (response bits `[32+TAG_W-1:32]`).
- `NR_REGIONS`, 4, number of programmable override regions, 1..16.
- `MAX_OUTSTANDING`, 4, depth of the per-transaction decision FIFO, power of two, >= 2.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `s_req_i, s_add_i[31:0], s_wen_i, s_be_i[3:0], s_wdata_i[32+TAG_W-1:0]`  in  upstream request (`wen`=1 means read).
- `s_gnt_o`  out  1  upstream grant.
- `s_r_valid_o`, `s_r_opc_o`, `s_r_rdata_o[32+TAG_W-1:0]`  out  upstream response.
- `m_req_o, m_add_o, m_wen_o, m_be_o, m_wdata_o`  out  downstream request, same widths as upstream.
- `m_gnt_i, m_r_valid_i, m_r_opc_i, m_r_rdata_i`  in  downstream grant and response.
- `cfg_req_i`  in  1  config access strobe, single cycle, always accepted.
- `cfg_we_i`  in  1  config write.
- `cfg_addr_i`  in  6  config word index.
- `cfg_wdata_i`  in  32  config write data.
- `cfg_rdata_o`  out  32  config read data, registered, valid the cycle after `cfg_req_i`.
- `err_o`  out  1  sticky: a response arrived with an empty FIFO.

## Operation
- Register map, region r: word 3r = START, word 3r+1 = END (exclusive), word 3r+2 = CTRL.
- CTRL fields: [0] EN, [2:1] MODE, [4+TAG_W-1:4] VALUE.
- Word 3·NR_REGIONS = STATUS: [0] err, [1] fifo_full, [2] fifo_empty. Writing 1 to bit 0 clears err.
- Unmapped reads return 0; unmapped writes are ignored.
- Match rule: `EN && START <= add < END`. The lowest-index matching region wins. If no region matches, MODE=0.
- MODE 0: pass the tag unchanged. MODE 1: all ones. MODE 2: all zeros. MODE 3: replace with VALUE.
- Request path is combinational pass-through, except:
  - `m_req_o = s_req_i && !full`
  - `s_gnt_o = m_gnt_i && !full`
- On `s_req_i && s_gnt_o`, push {MODE, VALUE} into the FIFO. This applies to reads and writes alike, because every request produces exactly one response.
- On `m_r_valid_i`, pop the FIFO:
  - Data bits `[31:0]` and `r_opc` pass through.
  - Tag bits are the popped mode applied to `m_r_rdata_i` tags.
  - Write responses are forwarded unchanged apart from the tag transform; the data is don't-care.
- Response with an empty FIFO: forward unmodified (MODE 0), set err, and do not pop.
- A push and a pop in the same cycle are both performed and the count is unchanged. This is legal when full, but gnt stays low during that cycle.
- A config write takes effect for requests granted from the next cycle onward. In-flight transactions keep their captured mode.
- Reset mid-operation clears all state:
  - FIFO empty, err=0.
  - All regions START=0, END=0, CTRL=0, i.e. disabled.
  - `cfg_rdata_o`=0.
  - Responses arriving after reset follow the empty-FIFO rule.

## Timing
- Request and response paths: 0-cycle combinational latency.
- Override decision: evaluated combinationally from `s_add_i` and the region registers in the grant cycle, then registered into the FIFO.
- `cfg_rdata_o`: 1-cycle latency, holds its value until the next read.
- FIFO full: `s_gnt_o` is held low until at least one pop. There is no throughput loss while the count is below `MAX_OUTSTANDING`.
- All outputs reset to 0 except pass-through signals, which follow their inputs.

## Configuration
- `DIFT_TAG_OVR_STATS_EN` defined:
  - Adds a 32-bit counter of read responses whose tag was changed by MODE 1–3 (MODE 0 is not counted). The counter saturates at 0xFFFF_FFFF.
  - Readable at word 3·NR_REGIONS+1; any write to that word clears it to 0.
  - Reset value 0.
- Macro undefined: no counter logic, and word 3·NR_REGIONS+1 reads 0.

## Test plan
- Reset, then read 0x1C00_0000 with downstream tag 0xA -> upstream tag 0xA; STATUS reads 0x4.
- Program region 0: [0x1C00_0000, 0x1C01_0000), MODE 1; region 1: same range, MODE 2. Read 0x1C00_0100 -> tag 0xF (priority). Read 0x1C01_0000 -> tag passed through (END exclusive).
- Region 2 MODE 3, VALUE=0x5. Issue 4 back-to-back reads alternating in/out of range with 3-cycle response delay -> tags 0x5, orig, 0x5, orig. A 5th request sees `s_gnt_o`=0 until the first response.
- Reprogram region 2 to MODE 2 while 2 reads are in flight -> those return 0x5; the next granted read returns 0x0.
- Inject `m_r_valid_i` with an empty FIFO -> data forwarded, `err_o`=1. Write STATUS bit0=1 -> `err_o`=0 the next cycle.
- With `DIFT_TAG_OVR_STATS_EN`: 3 overridden reads plus 2 pass reads -> counter = 3. Assert `rst_i` for 1 cycle mid-burst -> counter 0, FIFO empty, all regions disabled.
